acc_drain_requant: RTL and testbench
====================================

Name: acc_drain_requant

Overview:
Downstream stage of the systolic PE array. On a capture pulse it snapshots one column of NUM_ROWS PE accumulator outputs in parallel. It then serializes them over a valid/ready stream, requantizing each value back to operand width with optional ReLU, a rounding right shift and saturation. This frees the array to start its next tile while the previous results drain to the activation buffer.

Parameters:
ACC_WIDTH, 17, width of each PE accumulator value (signed)
DATA_WIDTH, 9, width of requantized output (signed), matches array operand width
NUM_ROWS, 4, number of accumulators captured per snapshot (>=2)
SHIFT_WIDTH, 4, width of the right-shift amount (shift range 0..2^SHIFT_WIDTH-1)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
capture_i  input  1  snapshot request, accepted only when capture_ready_o=1
acc_i  input  NUM_ROWS*ACC_WIDTH  flattened signed accumulators, row r at bits [r*ACC_WIDTH +: ACC_WIDTH]
shift_i  input  SHIFT_WIDTH  right-shift amount, sampled with capture
relu_en_i  input  1  ReLU enable, sampled with capture
capture_ready_o  output  1  high when IDLE (snapshot can be accepted)
out_valid_o  output  1  output element valid
out_ready_i  input  1  downstream ready
out_data_o  output  DATA_WIDTH  signed requantized element
out_idx_o  output  max(1,$clog2(NUM_ROWS))  row index of current element
out_last_o  output  1  high with the element for row NUM_ROWS-1
done_o  output  1  one-cycle pulse after the final element transfers

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, snapshot buffer=0, idx=0, latched shift=0, latched relu=0. Outputs: capture_ready_o=1, out_valid_o=0, out_data_o=0, out_idx_o=0, out_last_o=0, done_o=0. Asserting reset mid-drain aborts the drain; remaining elements are discarded.
- FSM states: IDLE, DRAIN.
- IDLE: capture_ready_o=1, out_valid_o=0. If capture_i=1, then on that edge: latch all NUM_ROWS of acc_i, shift_i and relu_en_i; set idx=0; go to DRAIN.
- DRAIN: capture_ready_o=0 and out_valid_o=1. First valid appears the cycle after capture, giving 1-cycle latency. capture_i is ignored in DRAIN, with no queuing and no error.
- Transfer occurs when out_valid_o and out_ready_i are both high at a rising edge.
  - On a transfer with idx<NUM_ROWS-1: idx increments.
  - On a transfer with idx=NUM_ROWS-1: go to IDLE, idx=0, and done_o=1 for exactly the next cycle.
- While out_valid_o=1 and out_ready_i=0, out_data_o, out_idx_o and out_last_o hold stable.
- With ready held high, one element transfers per cycle, so a full drain takes NUM_ROWS cycles.
- A capture can be accepted in the same cycle done_o is high. Back-to-back drains therefore have exactly one IDLE cycle between them.
- out_last_o = (state==DRAIN && idx==NUM_ROWS-1).
- out_data_o is a registered function of the buffer entry selected by idx, computed from the latched configuration:
  - Step 1, ReLU: if relu=1 and x<0, x=0.
  - Step 2, rounding: if s>0, x = x + 2^(s-1). This add is done at ACC_WIDTH+1 bits so it cannot overflow.
  - Step 3, shift: arithmetic right shift by s (floor).
  - Step 4, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. [-256, 255] at default.
- shift_i and relu_en_i changing during DRAIN have no effect on the current drain.
- acc_i changing after the capture edge has no effect; the snapshot is isolated.

Test Plan:
1. Reset, then capture acc={1000,-7,300,-65536}, shift=2, relu=0, ready=1 -> valid from the next cycle for 4 consecutive cycles. Data {250,-2,75,-16384→-256}, idx 0..3, last only on idx 3, done pulse one cycle after the 4th transfer.
2. Requant corners, shift=1, relu=0: acc=-7 -> -3; acc=1030 at shift=2 -> 255 (saturated). At shift=0: acc=300 -> 255 and acc=-65536 -> -256. At shift=15: acc=65535 -> 2 (no rounding overflow).
3. relu=1, acc={-7,-1,5,600}, shift=0 -> {0,0,5,255}.
4. Backpressure: ready low for 3 cycles while idx=1 -> data, idx and last held stable, valid stays 1. Releasing ready resumes at idx 1, with no loss and no duplication.
5. capture_i pulsed during DRAIN with different acc_i -> ignored, and the current drain outputs are unchanged. Capture asserted in the done_o cycle -> accepted, with valid returning the following cycle.
6. rstn asserted after 2 of 4 transfers -> outputs immediately at reset values. After release, state is IDLE and capture_ready_o=1; a new capture drains from idx 0 with the new data.

Source files
------------

// File: rtl/acc_drain_requant.sv
// rtl/acc_drain_requant.sv - snapshot a column of PE accumulators and drain it as
// requantized (ReLU, rounding shift, saturate) elements over a valid/ready stream.
module acc_drain_requant #(
  parameter int ACC_WIDTH   = 17,
  parameter int DATA_WIDTH  = 9,
  parameter int NUM_ROWS    = 4,
  parameter int SHIFT_WIDTH = 4,
  localparam int IDX_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          capture_i,
  input  logic [NUM_ROWS*ACC_WIDTH-1:0] acc_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic                          relu_en_i,
  output logic                          capture_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [IDX_W-1:0]              out_idx_o,
  output logic                          out_last_o,
  output logic                          done_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    buf_q [NUM_ROWS];
  logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
  logic [SHIFT_WIDTH-1:0]  shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    cap_fire;
  logic                    is_last;

  // Rounding add is carried at ACC_WIDTH+1 bits so a large positive value cannot wrap.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0]   a,
    input logic [SHIFT_WIDTH-1:0] s,
    input logic                   relu
  );
    logic signed [ACC_WIDTH:0] x;
    logic signed [ACC_WIDTH:0] rnd;
    x = $signed({a[ACC_WIDTH-1], a});
    if (relu && x[ACC_WIDTH]) x = '0;
    rnd = '0;
    if (s != '0) rnd = (ACC_WIDTH+1)'(1) << (s - 1'b1);
    x = x + rnd;
    x = x >>> s;
    if (x > SAT_MAX) x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
    return x[DATA_WIDTH-1:0];
  endfunction

  assign idx_nxt = idx_q + 1'b1;
  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    data_d   = data_q;
    done_d   = 1'b0;
    cap_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_i) begin
          cap_fire = 1'b1;
          state_d  = DRAIN;
          idx_d    = '0;
          shift_d  = shift_i;
          relu_d   = relu_en_i;
          // Row 0 comes straight from the input since the buffer loads on this same edge.
          data_d   = requant(acc_i[ACC_WIDTH-1:0], shift_i, relu_en_i);
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            data_d = requant(buf_q[idx_nxt], shift_q, relu_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_ROWS; r++) buf_q[r] <= '0;
    end else if (cap_fire) begin
      for (int r = 0; r < NUM_ROWS; r++) buf_q[r] <= acc_i[r*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign capture_ready_o = (state_q == IDLE);
  assign out_valid_o     = (state_q == DRAIN);
  assign out_data_o      = data_q;
  assign out_idx_o       = idx_q;
  assign out_last_o      = (state_q == DRAIN) && is_last;
  assign done_o          = done_q;

endmodule

// File: tb/tb_acc_drain_requant.sv
// tb/tb_acc_drain_requant.sv - scoreboard bench for acc_drain_requant with a
// behavioural requantization model and randomized capture/backpressure traffic.
module tb_acc_drain_requant;
  localparam int ACC_W = 17;
  localparam int DW    = 9;
  localparam int NR    = 4;
  localparam int SW    = 4;
  localparam int IW    = 2;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                capture_i = 1'b0;
  logic [NR*ACC_W-1:0] acc_i = '0;
  logic [SW-1:0]       shift_i = '0;
  logic                relu_en_i = 1'b0;
  logic                capture_ready_o;
  logic                out_valid_o;
  logic                out_ready_i = 1'b0;
  logic [DW-1:0]       out_data_o;
  logic [IW-1:0]       out_idx_o;
  logic                out_last_o;
  logic                done_o;

  acc_drain_requant #(.ACC_WIDTH(ACC_W), .DATA_WIDTH(DW), .NUM_ROWS(NR), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rstn(rstn), .capture_i(capture_i), .acc_i(acc_i), .shift_i(shift_i),
    .relu_en_i(relu_en_i), .capture_ready_o(capture_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_idx_o(out_idx_o),
    .out_last_o(out_last_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int idx; bit last; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   m_busy   = 1'b0;
  bit   m_done   = 1'b0;
  int   m_rem    = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Reference: clamp(floor((relu(a) + round) / 2^s)) in plain integer arithmetic.
  function automatic int requant_ref(input int a, input int s, input bit relu);
    int x, d, q;
    x = a;
    if (relu && x < 0) x = 0;
    if (s > 0) x = x + (1 << (s - 1));
    d = 1 << s;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    if (q > (1 << (DW - 1)) - 1) q = (1 << (DW - 1)) - 1;
    if (q < -(1 << (DW - 1))) q = -(1 << (DW - 1));
    return q;
  endfunction

  // Transaction-level model: an accepted capture queues NR expected elements.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_rem  = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (capture_i) begin
          for (int r = 0; r < NR; r++) begin
            exp_t e;
            logic signed [ACC_W-1:0] a;
            a      = acc_i[r*ACC_W +: ACC_W];
            e.data = requant_ref(int'(a), int'(shift_i), relu_en_i);
            e.idx  = r;
            e.last = (r == NR - 1);
            exp_q.push_back(e);
          end
          m_busy = 1'b1;
          m_rem  = NR;
        end
      end else if (out_ready_i) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_valid", out_valid_o, 0);
      chk("rst_cap_ready", capture_ready_o, 1);
      chk("rst_data", int'(out_data_o), 0);
      chk("rst_done", done_o, 0);
    end else begin
      chk("capture_ready", capture_ready_o, !m_busy);
      chk("out_valid", out_valid_o, m_busy);
      chk("done", done_o, m_done);
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got idx %0d expected no element", out_idx_o);
        end else begin
          chk("data", int'($signed(out_data_o)), exp_q[0].data);
          chk("idx", int'(out_idx_o), exp_q[0].idx);
          chk("last", out_last_o, exp_q[0].last);
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    int v [NR];
    v = '{a0, a1, a2, a3};
    for (int r = 0; r < NR; r++) acc_i[r*ACC_W +: ACC_W] = ACC_W'(v[r]);
  endtask

  task automatic rand_acc();
    for (int r = 0; r < NR; r++) begin
      if ($urandom_range(0, 1) == 1) acc_i[r*ACC_W +: ACC_W] = ACC_W'($urandom);
      else acc_i[r*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 4000)) - 2000);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || m_done) && n < 60) begin
      tick();
      n++;
    end
    if (m_busy) begin
      n_checks++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic drain(input int a0, input int a1, input int a2, input int a3,
                       input int s, input bit relu);
    set_acc(a0, a1, a2, a3);
    shift_i = SW'(s);
    relu_en_i = relu;
    capture_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    capture_i = 1'b0;
    rand_acc();
    shift_i = SW'($urandom);
    relu_en_i = ~relu;
    wait_idle();
    tick();
  endtask

  initial begin
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    drain(1000, -7, 300, -65536, 2, 1'b0);
    drain(-7, 1030, 300, -65536, 1, 1'b0);
    drain(1030, -7, 3, 1, 2, 1'b0);
    drain(300, -65536, 0, -1, 0, 1'b0);
    drain(65535, -65536, 1, 16383, 15, 1'b0);
    drain(-7, -1, 5, 600, 0, 1'b1);

    // Backpressure while idx=1, with a stray capture and fresh acc during the drain.
    set_acc(11, -22, 33, -44);
    shift_i = 0;
    relu_en_i = 1'b0;
    capture_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    capture_i = 1'b0;
    tick();
    out_ready_i = 1'b0;
    capture_i = 1'b1;
    set_acc(5000, 5000, 5000, 5000);
    repeat (3) tick();
    capture_i = 1'b0;
    out_ready_i = 1'b1;
    wait_idle();
    tick();

    // Capture held through the drain: ignored until the done cycle, then accepted.
    set_acc(100, 200, -300, 400);
    shift_i = 1;
    capture_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    set_acc(-9, 9, -90, 90);
    shift_i = 3;
    repeat (5) tick();
    capture_i = 1'b0;
    wait_idle();
    tick();

    // Reset in the middle of a drain.
    set_acc(1, 2, 3, 4);
    shift_i = 0;
    capture_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    capture_i = 1'b0;
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_cap_ready", capture_ready_o, 1);
    chk("midrst_idx", int'(out_idx_o), 0);
    chk("midrst_last", out_last_o, 0);
    chk("midrst_data", int'(out_data_o), 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    drain(-100, 77, -255, 256, 0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      tick();
      capture_i = ($urandom_range(0, 2) == 0);
      rand_acc();
      shift_i = SW'($urandom);
      relu_en_i = $urandom_range(0, 1);
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
    capture_i = 1'b0;
    out_ready_i = 1'b1;
    wait_idle();
    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
